bldc_speed_meter: RTL and testbench

BLDC_SPEED_METER -- requirements
Module: bldc_speed_meter

---
 rtl/bldc_pkg.sv | 30 +++
 rtl/bldc_duty_stepper.sv | 58 +++++
 rtl/bldc_speed_meter.sv | 122 ++++++++++++
 tb/tb_bldc_speed_meter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC speed meter: commutation codes,
// meter state machine encoding and the default period counter width.
package bldc_pkg;

   localparam int unsigned CNT_W_DEFAULT = 23;

   typedef enum logic [2:0] {
      Comm0 = 3'd0,
      Comm1 = 3'd1,
      Comm2 = 3'd2,
      Comm3 = 3'd3,
      Comm4 = 3'd4,
      Comm5 = 3'd5
   } comm_state_e;

   // A revolution is the wrap from the last commutation step back to the first.
   localparam comm_state_e REV_WRAP_FROM = Comm5;
   localparam comm_state_e REV_WRAP_TO   = Comm0;

   typedef enum logic [1:0] {
      StUnprimed = 2'd0,
      StRun      = 2'd1,
      StStall    = 2'd2
   } meter_state_e;

   function automatic logic comm_legal(input logic [2:0] s);
      return s <= Comm5;
   endfunction

endpackage

// File: rtl/bldc_duty_stepper.sv
// Closed-loop duty stepper: nudges duty by one count per measured period toward
// the target, saturating between DUTY_MIN and DUTY_MAX.
module bldc_duty_stepper
   import bldc_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEFAULT,
   parameter int unsigned DUTY_MIN = 50,
   parameter int unsigned DUTY_MAX = 255,
   parameter int unsigned DEADBAND = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] target_clks,
   input  logic             step_en,
   input  logic             clr,
   output logic [7:0]       duty
);

   localparam int unsigned XW = CNT_W + 1;
   localparam logic [XW-1:0] DB = XW'(DEADBAND);
   localparam logic [7:0] DMIN = 8'(DUTY_MIN);
   localparam logic [7:0] DMAX = 8'(DUTY_MAX);

   logic [XW-1:0] w_period_x;
   logic [XW-1:0] w_target_x;
   logic [XW-1:0] w_hi;
   logic [XW-1:0] w_lo;
   logic [7:0]    w_duty_next;
   logic [7:0]    r_duty;

   // One extra bit keeps target+DEADBAND from wrapping; the low bound clamps at 0.
   assign w_period_x = {1'b0, period};
   assign w_target_x = {1'b0, target_clks};
   assign w_hi       = w_target_x + DB;
   assign w_lo       = (w_target_x > DB) ? (w_target_x - DB) : '0;

   always_comb begin
      w_duty_next = r_duty;
      if (clr) begin
         w_duty_next = DMIN;
      end else if (step_en) begin
         if (w_period_x > w_hi) begin
            if (r_duty < DMAX) w_duty_next = r_duty + 8'd1;
         end else if (w_period_x < w_lo) begin
            if (r_duty > DMIN) w_duty_next = r_duty - 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_duty <= DMIN;
      else          r_duty <= w_duty_next;
   end

   assign duty = r_duty;

endmodule

// File: rtl/bldc_speed_meter.sv
// BLDC revolution period meter with stall detection. Define BLDC_SPEED_CTRL_EN
// to compile in closed-loop duty regulation; otherwise duty is fixed at DUTY_MIN.
module bldc_speed_meter
   import bldc_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEFAULT,
   parameter int unsigned STALL_CLKS = 8000000,
   parameter int unsigned DUTY_MIN   = 50,
   parameter int unsigned DUTY_MAX   = 255,
   parameter int unsigned DEADBAND   = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       comm_state,
   input  logic [CNT_W-1:0] target_clks,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   output logic             stalled,
   output logic [7:0]       duty
);

   localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(STALL_CLKS);

   meter_state_e     r_state;
   meter_state_e     w_state_next;
   logic [2:0]       r_prev_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] r_period;
   logic             r_period_valid;
   logic             w_event;
   logic             w_stall_hit;
   logic             w_meas;
   logic             w_stall_enter;

   // Illegal codes never update r_prev_state, so 5 -> 7 -> 0 still wraps.
   assign w_event = (r_prev_state == REV_WRAP_FROM) && (comm_state == REV_WRAP_TO);

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_event)      w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (~&r_cnt) w_cnt_next = r_cnt + 1'b1;
   end

   // Compared on the next count so stalled rises in the cycle cnt shows STALL_CLKS.
   assign w_stall_hit = !w_event && (w_cnt_next == STALL_CNT);

   always_comb begin
      w_state_next  = r_state;
      w_meas        = 1'b0;
      w_stall_enter = 1'b0;
      unique case (r_state)
         StUnprimed: begin
            if (w_event) begin
               w_state_next = StRun;
            end else if (w_stall_hit) begin
               w_state_next  = StStall;
               w_stall_enter = 1'b1;
            end
         end
         StRun: begin
            if (w_event) begin
               w_meas = 1'b1;
            end else if (w_stall_hit) begin
               w_state_next  = StStall;
               w_stall_enter = 1'b1;
            end
         end
         StStall: begin
            if (w_event) w_state_next = StUnprimed;
         end
         default: w_state_next = StUnprimed;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state        <= StUnprimed;
         r_prev_state   <= '0;
         r_cnt          <= '0;
         r_period       <= '0;
         r_period_valid <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_cnt          <= w_cnt_next;
         r_period_valid <= w_meas;
         if (comm_legal(comm_state)) r_prev_state <= comm_state;
         if (w_meas)                 r_period     <= r_cnt;
      end
   end

   assign period       = r_period;
   assign period_valid = r_period_valid;
   assign stalled      = (r_state == StStall);

`ifdef BLDC_SPEED_CTRL_EN
   logic w_step_en;

   assign w_step_en = r_period_valid && (target_clks != '0);

   bldc_duty_stepper #(
      .CNT_W    (CNT_W),
      .DUTY_MIN (DUTY_MIN),
      .DUTY_MAX (DUTY_MAX),
      .DEADBAND (DEADBAND)
   ) u_duty_stepper (
      .clk         (clk),
      .reset_n     (reset_n),
      .period      (r_period),
      .target_clks (target_clks),
      .step_en     (w_step_en),
      .clr         (w_stall_enter),
      .duty        (duty)
   );
`else
   logic w_unused_target;

   assign w_unused_target = ^target_clks ^ w_stall_enter;
   assign duty            = 8'(DUTY_MIN);
`endif

endmodule

// File: tb/tb_bldc_speed_meter.sv
// Directed bench for bldc_speed_meter; duty expectations follow BLDC_SPEED_CTRL_EN.
module tb_bldc_speed_meter;

   localparam int unsigned CNT_W    = 23;
   localparam int unsigned DUTY_MIN = 50;
   // Low ceiling keeps the saturation run short.
   localparam int unsigned DUTY_MAX = 52;
`ifdef BLDC_SPEED_CTRL_EN
   localparam bit CTRL = 1'b1;
`else
   localparam bit CTRL = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic [2:0]       comm_state;
   logic [CNT_W-1:0] target_clks;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             stalled;
   logic [7:0]       duty;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_valid  = 0;
   int   n_wide   = 0;
   logic last_valid = 1'b0;
   int   nv0;
   logic [7:0] exp_duty;

   bldc_speed_meter #(
      .CNT_W      (CNT_W),
      .STALL_CLKS (10000),
      .DUTY_MIN   (DUTY_MIN),
      .DUTY_MAX   (DUTY_MAX),
      .DEADBAND   (256)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .comm_state   (comm_state),
      .target_clks  (target_clks),
      .period       (period),
      .period_valid (period_valid),
      .stalled      (stalled),
      .duty         (duty)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (period_valid)               n_valid <= n_valid + 1;
      if (period_valid && last_valid) n_wide  <= n_wide + 1;
      last_valid <= period_valid;
   end

   task automatic hold(input logic [2:0] s, input int n);
      comm_state = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic rev(input int h);
      for (int k = 0; k < 6; k++) hold(3'(k), h);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; comm_state = 3'd0; target_clks = '0;
      repeat (3) @(negedge clk);
      n_checks++; if (period !== 23'd0) $display("FAIL rst_period got %0d want 0", period);
      else n_pass++;
      n_checks++; if (period_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", period_valid);
      else n_pass++;
      n_checks++; if (stalled !== 1'b0) $display("FAIL rst_stalled got %b want 0", stalled);
      else n_pass++;
      n_checks++; if (duty !== 8'd50) $display("FAIL rst_duty got %0d want 50", duty);
      else n_pass++;
      reset_n = 1'b1;
   endtask

   task automatic test_rotation();
      hold(3'd5, 10);
      rev(1000);
      n_checks++; if (n_valid !== 0) $display("FAIL rot_first got %0d pulses want 0", n_valid);
      else n_pass++;
      rev(1000);
      n_checks++; if (n_valid !== 1) $display("FAIL rot_second got %0d pulses want 1", n_valid);
      else n_pass++;
      n_checks++; if (period !== 23'd6000) $display("FAIL rot_period got %0d want 6000", period);
      else n_pass++;
      hold(3'd0, 1);
      n_checks++; if (period_valid !== 1'b1) $display("FAIL rot_pulse got %b want 1", period_valid);
      else n_pass++;
      hold(3'd0, 1);
      n_checks++; if (period_valid !== 1'b0) $display("FAIL rot_pulse_end got %b want 0", period_valid);
      else n_pass++;
      hold(3'd0, 998);
      for (int k = 1; k < 6; k++) hold(3'(k), 1000);
      n_checks++; if (n_valid !== 2) $display("FAIL rot_third got %0d pulses want 2", n_valid);
      else n_pass++;
      n_checks++; if (n_wide !== 0) $display("FAIL rot_width got %0d wide pulses want 0", n_wide);
      else n_pass++;
      n_checks++; if (duty !== 8'd50) $display("FAIL rot_duty got %0d want 50", duty);
      else n_pass++;
   endtask

   task automatic test_regulation();
      logic [7:0] up_exp [3];
      up_exp = '{8'd51, 8'd52, 8'd52};
      target_clks = 23'd4000;
      for (int r = 0; r < 3; r++) begin
         rev(1000);
         exp_duty = CTRL ? up_exp[r] : 8'd50;
         n_checks++;
         if (duty !== exp_duty) $display("FAIL reg_duty%0d got %0d want %0d", r, duty, exp_duty);
         else n_pass++;
         n_checks++;
         if (period !== 23'd6000) $display("FAIL reg_period%0d got %0d want 6000", r, period);
         else n_pass++;
      end
   endtask

   task automatic test_deadband();
      target_clks = 23'd6000;
      for (int k = 0; k < 5; k++) hold(3'(k), 1000);
      hold(3'd5, 1100);
      rev(500);
      n_checks++; if (period !== 23'd6100) $display("FAIL db_period got %0d want 6100", period);
      else n_pass++;
      exp_duty = CTRL ? 8'd52 : 8'd50;
      n_checks++; if (duty !== exp_duty) $display("FAIL db_duty got %0d want %0d", duty, exp_duty);
      else n_pass++;
   endtask

   task automatic test_stall();
      nv0 = n_valid;
      hold(3'd0, 1);
      hold(3'd3, 9997);
      hold(3'd3, 1);
      n_checks++; if (stalled !== 1'b0) $display("FAIL stall_early got %b want 0", stalled);
      else n_pass++;
      exp_duty = CTRL ? 8'd51 : 8'd50;
      n_checks++; if (duty !== exp_duty) $display("FAIL stall_pre_duty got %0d want %0d", duty, exp_duty);
      else n_pass++;
      n_checks++; if (n_valid !== nv0 + 1) $display("FAIL stall_pre_valid got %0d want %0d", n_valid, nv0 + 1);
      else n_pass++;
      hold(3'd3, 1);
      n_checks++; if (stalled !== 1'b1) $display("FAIL stall_set got %b want 1", stalled);
      else n_pass++;
      n_checks++; if (duty !== 8'd50) $display("FAIL stall_duty got %0d want 50", duty);
      else n_pass++;
      n_checks++; if (period !== 23'd3000) $display("FAIL stall_period got %0d want 3000", period);
      else n_pass++;
      hold(3'd3, 100);
      hold(3'd5, 10);
      hold(3'd0, 1);
      n_checks++; if (stalled !== 1'b0) $display("FAIL stall_clear got %b want 0", stalled);
      else n_pass++;
      hold(3'd0, 9);
      for (int k = 1; k < 6; k++) hold(3'(k), 500);
      n_checks++; if (n_valid !== nv0 + 1) $display("FAIL stall_no_valid got %0d want %0d", n_valid, nv0 + 1);
      else n_pass++;
   endtask

   task automatic test_floor();
      rev(600);
      n_checks++; if (n_valid !== nv0 + 1) $display("FAIL floor_prime got %0d want %0d", n_valid, nv0 + 1);
      else n_pass++;
      hold(3'd0, 5);
      n_checks++; if (n_valid !== nv0 + 2) $display("FAIL floor_valid got %0d want %0d", n_valid, nv0 + 2);
      else n_pass++;
      n_checks++; if (period !== 23'd3600) $display("FAIL floor_period got %0d want 3600", period);
      else n_pass++;
      n_checks++; if (duty !== 8'd50) $display("FAIL floor_duty got %0d want 50", duty);
      else n_pass++;
   endtask

   task automatic test_glitch();
      nv0 = n_valid;
      for (int k = 1; k < 6; k++) hold(3'(k), 500);
      hold(3'd7, 3);
      hold(3'd0, 10);
      n_checks++; if (period !== 23'd2508) $display("FAIL gl_period got %0d want 2508", period);
      else n_pass++;
      n_checks++; if (n_valid !== nv0 + 1) $display("FAIL gl_valid got %0d want %0d", n_valid, nv0 + 1);
      else n_pass++;
      hold(3'd5, 10);
      hold(3'd4, 10);
      n_checks++; if (n_valid !== nv0 + 1) $display("FAIL rev_valid got %0d want %0d", n_valid, nv0 + 1);
      else n_pass++;
      n_checks++; if (period !== 23'd2508) $display("FAIL rev_period got %0d want 2508", period);
      else n_pass++;
      hold(3'd5, 10);
      hold(3'd0, 5);
      n_checks++; if (period !== 23'd40) $display("FAIL rev_count got %0d want 40", period);
      else n_pass++;
      n_checks++; if (n_valid !== nv0 + 2) $display("FAIL rev_next got %0d want %0d", n_valid, nv0 + 2);
      else n_pass++;
      n_checks++; if (duty !== 8'd50) $display("FAIL gl_duty got %0d want 50", duty);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      hold(3'd0, 2995);
      reset_n = 1'b0;
      @(negedge clk);
      n_checks++; if (period !== 23'd0) $display("FAIL mrst_period got %0d want 0", period);
      else n_pass++;
      n_checks++; if (period_valid !== 1'b0) $display("FAIL mrst_valid got %b want 0", period_valid);
      else n_pass++;
      n_checks++; if (stalled !== 1'b0) $display("FAIL mrst_stalled got %b want 0", stalled);
      else n_pass++;
      n_checks++; if (duty !== 8'd50) $display("FAIL mrst_duty got %0d want 50", duty);
      else n_pass++;
      reset_n = 1'b1;
      nv0 = n_valid;
      hold(3'd5, 10);
      hold(3'd0, 10);
      n_checks++; if (n_valid !== nv0) $display("FAIL mrst_event got %0d want %0d", n_valid, nv0);
      else n_pass++;
      n_checks++; if (period !== 23'd0) $display("FAIL mrst_hold got %0d want 0", period);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rotation();
      test_regulation();
      test_deadband();
      test_stall();
      test_floor();
      test_glitch();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
